// File: rtl/fpmul_stage_if.sv
// rtl/fpmul_stage_if.sv - handshake and multiplier bus bundle for fpmul_stage
//
// Purpose: groups the operand/result handshakes, the ieee_mul side-bus and the
// flag/counter status of fpmul_stage into one interface.
// Modports:
//   slave  - the pipeline stage (fpmul_stage)
//   master - whoever feeds operands, supplies ieee_mul and consumes results
// Signals:
//   in_valid/in_ready/in_a/in_b       operand handshake
//   mul_a/mul_b/mul_s                 combinational multiplier hookup
//   out_valid/out_ready/out_s         result handshake
//   out_flags/sticky/flag_clr         {nv, of, uf} per result and accumulated
//   res_cnt                           completed-result counter (wraps)

interface fpmul_stage_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic [31:0]      mul_s;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_s;
  logic [2:0]       out_flags;
  logic [2:0]       sticky;
  logic             flag_clr;
  logic [CNT_W-1:0] res_cnt;

  modport slave (
    input  in_valid, in_a, in_b, mul_s, out_ready, flag_clr,
    output in_ready, mul_a, mul_b, out_valid, out_s, out_flags, sticky, res_cnt
  );

  modport master (
    output in_valid, in_a, in_b, mul_s, out_ready, flag_clr,
    input  in_ready, mul_a, mul_b, out_valid, out_s, out_flags, sticky, res_cnt
  );
endinterface

// File: rtl/fpmul_stage.sv
// rtl/fpmul_stage.sv - two-register pipeline around the combinational ieee_mul
//
// Purpose: S1 registers the operands (driving ieee_mul directly) together with
// their IEEE-754 class and the biased product exponent. S2 registers the final
// result after special-case selection and overflow/underflow detection, which
// the raw multiplier does not perform. Mantissa is the multiplier's truncated
// output, untouched.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset; drops in-flight work, clears status
//   bus   - fpmul_stage_if.slave (operand/result handshakes, ieee_mul bus,
//           out_flags {nv,of,uf}, sticky flags, flag_clr, res_cnt)

module fpmul_stage #(
  parameter int          CNT_W = 16,
  parameter logic [31:0] QNAN  = 32'h7FC00000
) (
  input  logic         clk,
  input  logic         rst,
  fpmul_stage_if.slave bus
);

  // S1: operand register plus precomputed classification
  logic              s1_valid;
  logic [31:0]       s1_a;
  logic [31:0]       s1_b;
  logic              s1_sign;
  logic              s1_a_zero, s1_a_inf, s1_a_nan;
  logic              s1_b_zero, s1_b_inf, s1_b_nan;
  logic signed [9:0] s1_e;

  // S2: result register
  logic              s2_valid;
  logic [31:0]       s2_s;
  logic [2:0]        s2_flags;

  logic [2:0]        sticky_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              s2_load;
  logic              in_fire;
  logic              out_fire;

  // Input-side classification, registered into S1
  logic              a_zero, a_inf, a_nan;
  logic              b_zero, b_inf, b_nan;
  logic signed [9:0] in_e;

  // S2 result selection
  logic              norm_carry;
  logic signed [9:0] e_final;
  logic [31:0]       res_s;
  logic [2:0]        res_flags;

  // The multiplier's sign bit is recomputed here from the operand signs.
  logic              unused_mul_sign;
  assign unused_mul_sign = bus.mul_s[31];

  assign s2_load  = !s2_valid || bus.out_ready;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = s2_valid && bus.out_ready;

  assign bus.in_ready  = !rst && (!s1_valid || s2_load);
  assign bus.mul_a     = s1_a;
  assign bus.mul_b     = s1_b;
  assign bus.out_valid = s2_valid;
  assign bus.out_s     = s2_s;
  assign bus.out_flags = s2_flags;
  assign bus.sticky    = sticky_q;
  assign bus.res_cnt   = cnt_q;

  // Denormals have exponent field 0 and are treated as zero (flush to zero).
  always_comb begin
    a_zero = (bus.in_a[30:23] == 8'h00);
    a_inf  = (bus.in_a[30:23] == 8'hFF) && (bus.in_a[22:0] == 23'h0);
    a_nan  = (bus.in_a[30:23] == 8'hFF) && (bus.in_a[22:0] != 23'h0);
    b_zero = (bus.in_b[30:23] == 8'h00);
    b_inf  = (bus.in_b[30:23] == 8'hFF) && (bus.in_b[22:0] == 23'h0);
    b_nan  = (bus.in_b[30:23] == 8'hFF) && (bus.in_b[22:0] != 23'h0);
    // ea + eb - 127 spans -127..383, which fits 10-bit two's complement.
    in_e   = $signed({2'b00, bus.in_a[30:23]} + {2'b00, bus.in_b[30:23]} - 10'd127);
  end

  // The multiplier reports only the low 8 bits of its exponent; if they differ
  // from E[7:0] the mantissa product carried into bit 1 and the true exponent
  // is E + 1. Range checks are done on that 10-bit value.
  always_comb begin
    res_s      = '0;
    res_flags  = '0;
    norm_carry = (bus.mul_s[30:23] != s1_e[7:0]);
    e_final    = $signed(s1_e + {9'b0, norm_carry});
    if (s1_a_nan || s1_b_nan || (s1_a_inf && s1_b_zero) || (s1_a_zero && s1_b_inf)) begin
      res_s     = QNAN;
      res_flags = 3'b100;
    end else if (s1_a_inf || s1_b_inf) begin
      res_s = {s1_sign, 8'hFF, 23'h0};
    end else if (s1_a_zero || s1_b_zero) begin
      res_s = {s1_sign, 31'h0};
    end else if (e_final >= 10'sd255) begin
      res_s     = {s1_sign, 8'hFF, 23'h0};
      res_flags = 3'b010;
    end else if (e_final <= 10'sd0) begin
      res_s     = {s1_sign, 31'h0};
      res_flags = 3'b001;
    end else begin
      res_s = {s1_sign, bus.mul_s[30:0]};
    end
  end

  // S1: holds while full and S2 cannot take its contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_sign   <= 1'b0;
      s1_a_zero <= 1'b0;
      s1_a_inf  <= 1'b0;
      s1_a_nan  <= 1'b0;
      s1_b_zero <= 1'b0;
      s1_b_inf  <= 1'b0;
      s1_b_nan  <= 1'b0;
      s1_e      <= '0;
    end else if (!s1_valid || s2_load) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_a      <= bus.in_a;
        s1_b      <= bus.in_b;
        s1_sign   <= bus.in_a[31] ^ bus.in_b[31];
        s1_a_zero <= a_zero;
        s1_a_inf  <= a_inf;
        s1_a_nan  <= a_nan;
        s1_b_zero <= b_zero;
        s1_b_inf  <= b_inf;
        s1_b_nan  <= b_nan;
        s1_e      <= in_e;
      end
    end
  end

  // S2: result data only changes when a new transaction moves in, so a
  // stalled result stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_s     <= '0;
      s2_flags <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_s     <= res_s;
        s2_flags <= res_flags;
      end
    end
  end

  // Sticky flags and result counter. A clear coinciding with a handshake
  // leaves exactly that handshake's flags (set wins over clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (bus.flag_clr) begin
        sticky_q <= out_fire ? s2_flags : 3'b000;
      end else if (out_fire) begin
        sticky_q <= sticky_q | s2_flags;
      end
      if (out_fire) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fpmul_stage.sv
// tb/tb_fpmul_stage.sv - self-checking bench for fpmul_stage
//
// Purpose: directed and randomized checks of fpmul_stage against a reference
// model, with a behavioural truncating ieee_mul attached to the mul bus.
// Ports: none (top-level bench).

module tb_fpmul_stage;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpmul_stage_if #(.CNT_W(CNT_W)) bus ();

  fpmul_stage #(.CNT_W(CNT_W), .QNAN(32'h7FC00000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural stand-in for the combinational ieee_mul: truncating, keeps
  // only the low 8 bits of the exponent, no special cases.
  function automatic logic [31:0] ieee_mul_model(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic        n;
    logic [22:0] f;
    logic [7:0]  e;
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    n = p[47];
    f = n ? p[46:24] : p[45:23];
    e = a[30:23] + b[30:23] - 8'd127 + {7'b0, n};
    return {a[31] ^ b[31], e, f};
  endfunction

  assign bus.mul_s = ieee_mul_model(bus.mul_a, bus.mul_b);

  // Reference: IEEE-754 single multiply with flush-to-zero, truncation and
  // saturation to inf/zero on exponent overflow/underflow.
  function automatic void ref_result(input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] s, output logic [2:0] f);
    int ea, eb, e;
    bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sg, carry;
    longint unsigned ma, mb, p;
    logic [22:0] frac;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    sg = a[31] ^ b[31];
    f  = 3'b000;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      s = 32'h7FC00000;
      f = 3'b100;
    end else if (a_inf || b_inf) begin
      s = {sg, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      s = {sg, 31'h0};
    end else begin
      ma = 64'(a[22:0]) + 64'h80_0000;
      mb = 64'(b[22:0]) + 64'h80_0000;
      p  = ma * mb;
      carry = (p >= 64'h8000_0000_0000);
      e  = ea + eb - 127 + (carry ? 1 : 0);
      frac = carry ? 23'(p >> 24) : 23'(p >> 23);
      if (e >= 255) begin
        s = {sg, 8'hFF, 23'h0};
        f = 3'b010;
      end else if (e <= 0) begin
        s = {sg, 31'h0};
        f = 3'b001;
      end else begin
        s = {sg, 8'(e), frac};
      end
    end
  endfunction

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [2:0]  expf_q[$];
  logic [2:0]  m_sticky;
  logic [CNT_W-1:0] m_cnt;
  logic last_in_fire;
  logic last_out_fire;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, update the model, check
  // sticky/res_cnt just after the edge.
  task automatic cycle();
    logic [31:0] rs;
    logic [2:0]  rf;
    logic [2:0]  fl_now;
    fl_now = 3'b000;
    @(negedge clk);
    last_in_fire  = bus.in_valid && bus.in_ready;
    last_out_fire = bus.out_valid && bus.out_ready;
    if (last_out_fire) begin
      if (exp_q.size() == 0) begin
        chk("spurious_output", 32'(bus.out_valid), 32'd0);
      end else begin
        fl_now = expf_q.pop_front();
        chk("out_s", bus.out_s, exp_q.pop_front());
        chk("out_flags", 32'(bus.out_flags), 32'(fl_now));
      end
      m_cnt = m_cnt + 1'b1;
    end
    if (bus.flag_clr) m_sticky = fl_now;
    else              m_sticky = m_sticky | fl_now;
    if (last_in_fire) begin
      ref_result(bus.in_a, bus.in_b, rs, rf);
      exp_q.push_back(rs);
      expf_q.push_back(rf);
    end
    @(posedge clk);
    #1;
    chk("sticky", 32'(bus.sticky), 32'(m_sticky));
    chk("res_cnt", 32'(bus.res_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.flag_clr = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_s", bus.out_s, 32'd0);
    chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
    chk("rst_sticky", 32'(bus.sticky), 32'd0);
    chk("rst_res_cnt", 32'(bus.res_cnt), 32'd0);
    chk("rst_mul_a", bus.mul_a, 32'd0);
    chk("rst_mul_b", bus.mul_b, 32'd0);
    chk("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    expf_q.delete();
    m_sticky = 3'b000;
    m_cnt = '0;
    @(posedge clk);
    #1;
    chk("rst_in_ready_after", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic directed(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_s, input logic [2:0] exp_f);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    chk("dir_out_valid", 32'(bus.out_valid), 32'd1);
    chk("dir_out_s", bus.out_s, exp_s);
    chk("dir_out_flags", 32'(bus.out_flags), 32'(exp_f));
    cycle();
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    int cls;
    r = $urandom;
    cls = $urandom_range(0, 9);
    case (cls)
      0: r[30:0] = 31'h0;
      1: begin r[30:23] = 8'h00; if (r[22:0] == 0) r[0] = 1'b1; end
      2: begin r[30:23] = 8'hFF; r[22:0] = 23'h0; end
      3: begin r[30:23] = 8'hFF; if (r[22:0] == 0) r[5] = 1'b1; end
      4, 5: r[30:23] = 8'($urandom_range(1, 20));
      6, 7: r[30:23] = 8'($urandom_range(230, 254));
      default: r[30:23] = 8'($urandom_range(100, 154));
    endcase
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pa[4];
    logic [31:0] pb[4];
    logic [31:0] held;
    int idx;
    int budget;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b1;
    bus.flag_clr = 1'b0;
    m_sticky = 3'b000;
    m_cnt = '0;
    held = '0;
    #1;
    do_reset();

    // Basic products and special cases
    directed(32'h40000000, 32'h40400000, 32'h40C00000, 3'b000);
    chk("first_res_cnt", 32'(bus.res_cnt), 32'd1);
    directed(32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100);
    chk("sticky_nv", 32'(bus.sticky), 32'b100);
    directed(32'hFF800000, 32'h3F800000, 32'hFF800000, 3'b000);
    directed(32'h7E967699, 32'h7E967699, 32'h7F800000, 3'b010);
    directed(32'h00800000, 32'h3F000000, 32'h00000000, 3'b001);
    chk("sticky_accum", 32'(bus.sticky), 32'b111);

    // Clear coinciding with an overflow handshake, then clear alone
    bus.in_a = 32'h7E967699;
    bus.in_b = 32'h7E967699;
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    bus.flag_clr = 1'b1;
    cycle();
    chk("clr_with_of", 32'(bus.sticky), 32'b010);
    cycle();
    chk("clr_alone", 32'(bus.sticky), 32'b000);
    bus.flag_clr = 1'b0;

    // Backpressure with four queued pairs
    do_reset();
    pa[0] = 32'h3F800000; pb[0] = 32'h40000000;
    pa[1] = 32'h40400000; pb[1] = 32'h40800000;
    pa[2] = 32'hC0000000; pb[2] = 32'h3FC00000;
    pa[3] = 32'h41200000; pb[3] = 32'h41200000;
    idx = 0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_a = pa[idx];
      bus.in_b = pb[idx];
      cycle();
      if (last_in_fire) idx++;
      if (k == 1) held = bus.out_s;
      if (k == 2) chk("stall_out_s_stable", bus.out_s, held);
    end
    chk("stall_accepts", 32'(idx), 32'd2);
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    budget = 20;
    while ((idx < 4 || exp_q.size() != 0) && budget > 0) begin
      bus.in_valid = (idx < 4);
      if (idx < 4) begin
        bus.in_a = pa[idx];
        bus.in_b = pb[idx];
      end
      cycle();
      if (last_in_fire) idx++;
      budget--;
    end
    bus.in_valid = 1'b0;
    chk("stream_budget", 32'(budget > 0), 32'd1);
    chk("stream_res_cnt", 32'(bus.res_cnt), 32'd4);

    // Reset while both stages are full
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1;
      bus.in_a = pa[k];
      bus.in_b = pb[k];
      cycle();
    end
    bus.in_valid = 1'b0;
    chk("full_before_rst", 32'(bus.out_valid), 32'd1);
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("no_stale_result", 32'(bus.out_valid), 32'd0);
    end

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flag_clr  = ($urandom_range(0, 15) == 0);
      bus.in_a = rand_op();
      bus.in_b = rand_op();
      cycle();
    end
    bus.in_valid = 1'b0;
    bus.flag_clr = 1'b0;
    bus.out_ready = 1'b1;
    budget = 10;
    while (exp_q.size() != 0 && budget > 0) begin
      cycle();
      budget--;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
